reg32_rd: RTL

Burst read-back controller for the 16 x 32-bit register bank. Takes a start address and burst length, walks the bank's 16 parallel outputs with 4-bit wrap-around, and streams one word per handshake on a valid/ready read port. It is the host-side counterpart of the bank's write path and sits between the bank outputs and the bus or debug reader.

---
 rtl/reg32_pkg.sv | 19 +
 rtl/reg32_rd_mux.sv | 15 +
 rtl/reg32_rd.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/reg32_pkg.sv
// Shared constants and state encoding for the 16 x 32-bit register bank
// read-back path.
package reg32_pkg;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bank index successor; wraps 15 -> 0 by truncation to AW bits.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr);
        return addr + 4'd1;
    endfunction

endpackage

// File: rtl/reg32_rd_mux.sv
// Combinational 16:1 word selector over the bank outputs.
module reg32_rd_mux
    import reg32_pkg::*;
(
    input  logic [AW-1:0] sel,
    input  logic [DW-1:0] words [NREG],
    output logic [DW-1:0] word
);

    // Pick the addressed bank word.
    always_comb begin
        word = words[sel];
    end

endmodule

// File: rtl/reg32_rd.sv
// Burst read-back controller: streams words of the register bank onto a
// valid/ready port, starting at start_addr with 4-bit wrap-around.
module reg32_rd
    import reg32_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] burst_len,
    input  logic          abort,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    input  logic [DW-1:0] data_in4,
    input  logic [DW-1:0] data_in5,
    input  logic [DW-1:0] data_in6,
    input  logic [DW-1:0] data_in7,
    input  logic [DW-1:0] data_in8,
    input  logic [DW-1:0] data_in9,
    input  logic [DW-1:0] data_in10,
    input  logic [DW-1:0] data_in11,
    input  logic [DW-1:0] data_in12,
    input  logic [DW-1:0] data_in13,
    input  logic [DW-1:0] data_in14,
    input  logic [DW-1:0] data_in15,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last,
    output logic [AW-1:0] rd_idx,
    output logic          busy
);

    state_e        state_r;
    state_e        state_s;
    logic [AW-1:0] ptr_r;
    logic [AW-1:0] ptr_s;
    logic [AW-1:0] remaining_r;
    logic [AW-1:0] remaining_s;
    logic [DW-1:0] rd_data_s;
    logic          rd_valid_s;
    logic          rd_last_s;
    logic [AW-1:0] rd_idx_s;
    logic          busy_s;
    logic [AW-1:0] sel_s;
    logic [DW-1:0] word_s;
    logic [DW-1:0] bank_s [NREG];

    assign bank_s[0]  = data_in0;
    assign bank_s[1]  = data_in1;
    assign bank_s[2]  = data_in2;
    assign bank_s[3]  = data_in3;
    assign bank_s[4]  = data_in4;
    assign bank_s[5]  = data_in5;
    assign bank_s[6]  = data_in6;
    assign bank_s[7]  = data_in7;
    assign bank_s[8]  = data_in8;
    assign bank_s[9]  = data_in9;
    assign bank_s[10] = data_in10;
    assign bank_s[11] = data_in11;
    assign bank_s[12] = data_in12;
    assign bank_s[13] = data_in13;
    assign bank_s[14] = data_in14;
    assign bank_s[15] = data_in15;

    // One shared selector: the start address feeds the first word, ptr the rest.
    always_comb begin
        if (state_r == IDLE) begin
            sel_s = start_addr;
        end else begin
            sel_s = ptr_r;
        end
    end

    reg32_rd_mux u_mux (
        .sel   (sel_s),
        .words (bank_s),
        .word  (word_s)
    );

    // Next-state and next-output computation; every path defaults to hold.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        remaining_s = remaining_r;
        rd_data_s   = rd_data;
        rd_valid_s  = rd_valid;
        rd_last_s   = rd_last;
        rd_idx_s    = rd_idx;
        busy_s      = busy;
        case (state_r)
            IDLE: begin
                if (start) begin
                    rd_data_s   = word_s;
                    rd_idx_s    = start_addr;
                    rd_valid_s  = 1'b1;
                    rd_last_s   = (burst_len == 4'd0);
                    ptr_s       = next_addr(start_addr);
                    remaining_s = burst_len;
                    busy_s      = 1'b1;
                    state_s     = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // abort takes priority over a handshake in the same cycle
                if (abort) begin
                    rd_valid_s = 1'b0;
                    rd_last_s  = 1'b0;
                    busy_s     = 1'b0;
                    state_s    = IDLE;
                end else if (rd_valid && rd_ready) begin
                    if (remaining_r != 4'd0) begin
                        rd_data_s   = word_s;
                        rd_idx_s    = ptr_r;
                        rd_last_s   = (remaining_r == 4'd1);
                        ptr_s       = next_addr(ptr_r);
                        remaining_s = remaining_r - 4'd1;
                    end else begin
                        rd_valid_s = 1'b0;
                        rd_last_s  = 1'b0;
                        busy_s     = 1'b0;
                        state_s    = IDLE;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                rd_valid_s = 1'b0;
                rd_last_s  = 1'b0;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= 4'd0;
            remaining_r <= 4'd0;
            rd_data     <= 32'd0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_idx      <= 4'd0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            remaining_r <= remaining_s;
            rd_data     <= rd_data_s;
            rd_valid    <= rd_valid_s;
            rd_last     <= rd_last_s;
            rd_idx      <= rd_idx_s;
            busy        <= busy_s;
        end
    end

endmodule
